// File: rtl/timer_pkg.sv
// Shared timing-block types and field geometry for the stopwatch and countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } timer_state_t;

    localparam int HR_W  = 4;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int MS_W  = 10;

    localparam int MS_MAX_DEF  = 999;
    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 59;
    localparam int HR_MAX_DEF  = (1 << HR_W) - 1;

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/time_field_dec.sv
// One time field: clamped preset/load, reload, decrement with wrap-to-MAX and borrow-out.
module time_field_dec
    import timer_pkg::*;
#(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic         reload,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         borrow
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] preset_q;
    logic [W-1:0] clamped;

    assign clamped = (load_val > MAX_V) ? MAX_V : load_val;
    assign borrow  = dec && (value == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            preset_q <= '0;
            value    <= '0;
        end else if (en) begin
            if (load) begin
                preset_q <= clamped;
                value    <= clamped;
            end else if (reload) begin
                value <= preset_q;
            end else if (dec) begin
                value <= (value == '0) ? MAX_V : value - W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// H:M:S:ms countdown timer with start/stop edge detection and expiry flag.
// Optional AUTO_RELOAD_EN: reload the preset on expiry and keep running.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int MS_MAX   = MS_MAX_DEF,
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF
) (
    input  logic             Clock_1MSec,
    input  logic             Reset,
    input  logic             Control,
    input  logic             Load_T,
    input  logic             Start_T,
    input  logic             Stop_T,
    input  logic [HR_W-1:0]  Set_Hours,
    input  logic [MIN_W-1:0] Set_Mins,
    input  logic [SEC_W-1:0] Set_Secs,
    input  logic [MS_W-1:0]  Set_MSecs,
    output logic [HR_W-1:0]  Hours_T,
    output logic [MIN_W-1:0] Mins_T,
    output logic [SEC_W-1:0] Secs_T,
    output logic [MS_W-1:0]  MSecs_T,
    output logic             Running_T,
    output logic             Expired_T
);

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int DIV_W = div_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    timer_state_t state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic expired_q, expired_d;
    logic start_q, start_qq, stop_q, stop_qq;
    logic start_ev, stop_ev;
    logic tick, reload;
    logic cnt_zero, cnt_one;
    logic ms_b, sec_b, min_b, hr_b;

    // Two-stage copies: an event fires one edge after the input is sampled high.
    assign start_ev = start_q & ~start_qq;
    assign stop_ev  = stop_q & ~stop_qq;

    assign cnt_zero = (Hours_T == '0) && (Mins_T == '0)
                   && (Secs_T == '0) && (MSecs_T == '0);
    assign cnt_one  = (Hours_T == '0) && (Mins_T == '0)
                   && (Secs_T == '0) && (MSecs_T == MS_W'(1));

    always_ff @(posedge Clock_1MSec) begin
        if (!Reset) begin
            start_q  <= 1'b0;
            start_qq <= 1'b0;
            stop_q   <= 1'b0;
            stop_qq  <= 1'b0;
        end else begin
            start_q  <= Start_T;
            start_qq <= start_q;
            stop_q   <= Stop_T;
            stop_qq  <= stop_q;
        end
    end

    always_ff @(posedge Clock_1MSec) begin
        if (!Reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            expired_q <= 1'b0;
        end else if (Control) begin
            state_q   <= state_d;
            div_q     <= div_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        expired_d = expired_q;
        tick      = 1'b0;
        reload    = 1'b0;
        if (Load_T) begin
            state_d   = IDLE;
            div_d     = '0;
            expired_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ev && !stop_ev) begin
                        div_d = '0;
                        if (cnt_zero) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    expired_d = 1'b0;
                    if (stop_ev) begin
                        state_d = PAUSE;
                        div_d   = '0;
                    end else if (AUTO && cnt_zero) begin
                        reload = 1'b1;
                        div_d  = '0;
                    end else if (div_q == DIV_LAST) begin
                        tick  = 1'b1;
                        div_d = '0;
                        // This edge writes zero: flag expiry now.
                        if (cnt_one) begin
                            expired_d = 1'b1;
                            if (!AUTO) state_d = DONE;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                PAUSE: begin
                    if (start_ev && !stop_ev) begin
                        state_d = RUN;
                        div_d   = '0;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign Running_T = (state_q == RUN);
    assign Expired_T = expired_q;

    time_field_dec #(.W(MS_W), .MAX(MS_MAX)) u_ms (
        .clk      (Clock_1MSec),
        .rst_n    (Reset),
        .en       (Control),
        .load     (Load_T),
        .reload   (reload),
        .dec      (tick),
        .load_val (Set_MSecs),
        .value    (MSecs_T),
        .borrow   (ms_b)
    );

    time_field_dec #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (Clock_1MSec),
        .rst_n    (Reset),
        .en       (Control),
        .load     (Load_T),
        .reload   (reload),
        .dec      (ms_b),
        .load_val (Set_Secs),
        .value    (Secs_T),
        .borrow   (sec_b)
    );

    time_field_dec #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (Clock_1MSec),
        .rst_n    (Reset),
        .en       (Control),
        .load     (Load_T),
        .reload   (reload),
        .dec      (sec_b),
        .load_val (Set_Mins),
        .value    (Mins_T),
        .borrow   (min_b)
    );

    // The all-zero stop guarantees hours never wrap.
    time_field_dec #(.W(HR_W), .MAX(HR_MAX_DEF)) u_hr (
        .clk      (Clock_1MSec),
        .rst_n    (Reset),
        .en       (Control),
        .load     (Load_T),
        .reload   (reload),
        .dec      (min_b),
        .load_val (Set_Hours),
        .value    (Hours_T),
        .borrow   (hr_b)
    );

    logic unused_hr_b;
    assign unused_hr_b = hr_b;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed stimulus, queued expectations, negedge monitor.
module tb_countdown_timer;

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ctrl;
    logic       load;
    logic       start;
    logic       stop;
    logic [3:0] set_h;
    logic [5:0] set_m;
    logic [5:0] set_s;
    logic [9:0] set_ms;
    logic [3:0] hrs;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [9:0] msecs;
    logic       running;
    logic       expired;

    typedef struct {
        string       name;
        logic [27:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    countdown_timer dut (
        .Clock_1MSec (clk),
        .Reset       (rst_n),
        .Control     (ctrl),
        .Load_T      (load),
        .Start_T     (start),
        .Stop_T      (stop),
        .Set_Hours   (set_h),
        .Set_Mins    (set_m),
        .Set_Secs    (set_s),
        .Set_MSecs   (set_ms),
        .Hours_T     (hrs),
        .Mins_T      (mins),
        .Secs_T      (secs),
        .MSecs_T     (msecs),
        .Running_T   (running),
        .Expired_T   (expired)
    );

    always @(negedge clk) begin
        while (sb.size() != 0) begin
            exp_t e;
            logic [27:0] act;
            e   = sb.pop_front();
            act = {hrs, mins, secs, msecs, running, expired};
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %0d:%0d:%0d:%0d run=%0b exp=%0b, want %0d:%0d:%0d:%0d run=%0b exp=%0b",
                         e.name, act[27:24], act[23:18], act[17:12], act[11:2], act[1], act[0],
                         e.v[27:24], e.v[23:18], e.v[17:12], e.v[11:2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_t(input string n, input int h, input int m, input int s,
                            input int ms, input bit run, input bit ex);
        exp_t e;
        e.name = n;
        e.v    = {4'(h), 6'(m), 6'(s), 10'(ms), run, ex};
        sb.push_back(e);
    endtask

    task automatic do_load(input int h, input int m, input int s, input int ms);
        set_h  = 4'(h);
        set_m  = 6'(m);
        set_s  = 6'(s);
        set_ms = 10'(ms);
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n  = 1'b0;
        ctrl   = 1'b1;
        load   = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        set_h  = '0;
        set_m  = '0;
        set_s  = '0;
        set_ms = '0;
        step(2);
        expect_t("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        do_load(0, 0, 1, 5);
        expect_t("load_1005", 0, 0, 1, 5, 0, 0);
        start_pulse();
        expect_t("start_latency", 0, 0, 1, 5, 1, 0);
        step(1004);
        expect_t("count_one", 0, 0, 0, 1, 1, 0);
        step(1);
        expect_t("expire_edge", 0, 0, 0, 0, AUTO, 1);
        step(5);
        if (AUTO) expect_t("after_expire", 0, 0, 1, 1, 1, 0);
        else      expect_t("after_expire", 0, 0, 0, 0, 0, 1);

        do_load(0, 1, 0, 0);
        start_pulse();
        step(1);
        expect_t("borrow_min", 0, 0, 59, 999, 1, 0);
        do_load(1, 0, 0, 0);
        start_pulse();
        step(1);
        expect_t("borrow_hr", 0, 59, 59, 999, 1, 0);

        do_load(0, 0, 0, 100);
        start_pulse();
        step(9);
        expect_t("run_nine", 0, 0, 0, 91, 1, 0);
        stop_pulse();
        expect_t("paused", 0, 0, 0, 90, 0, 0);
        step(50);
        expect_t("pause_hold", 0, 0, 0, 90, 0, 0);
        start_pulse();
        expect_t("resume_edge", 0, 0, 0, 90, 1, 0);
        step(1);
        expect_t("resume_tick", 0, 0, 0, 89, 1, 0);

        do_load(0, 63, 0, 1023);
        expect_t("clamp_min_ms", 0, 59, 0, 999, 0, 0);
        do_load(15, 60, 61, 1000);
        expect_t("clamp_all", 15, 59, 59, 999, 0, 0);
        do_load(0, 0, 0, 0);
        start_pulse();
        expect_t("zero_start", 0, 0, 0, 0, 0, 1);
        start_pulse();
        expect_t("done_ignores_start", 0, 0, 0, 0, 0, 1);
        do_load(0, 0, 0, 5);
        expect_t("load_clears_exp", 0, 0, 0, 5, 0, 0);

        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        step(1);
        expect_t("both_idle", 0, 0, 0, 5, 0, 0);
        start_pulse();
        step(1);
        expect_t("run_to_4", 0, 0, 0, 4, 1, 0);
        ctrl   = 1'b0;
        set_ms = 10'd9;
        load   = 1'b1;
        step(20);
        load   = 1'b0;
        step(1);
        expect_t("ctrl_freeze", 0, 0, 0, 4, 1, 0);
        ctrl = 1'b1;
        step(1);
        expect_t("ctrl_resume", 0, 0, 0, 3, 1, 0);

        rst_n = 1'b0;
        step(1);
        expect_t("reset_mid_run", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        do_load(0, 0, 0, 3);
        start_pulse();
        step(3);
        expect_t("p3_zero", 0, 0, 0, 0, AUTO, 1);
        step(1);
        if (AUTO) expect_t("p3_reload", 0, 0, 0, 3, 1, 0);
        else      expect_t("p3_hold", 0, 0, 0, 0, 0, 1);
        step(3);
        expect_t("p3_zero2", 0, 0, 0, 0, AUTO, 1);
        step(4);
        expect_t("p3_zero3", 0, 0, 0, 0, AUTO, 1);

        step(2);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
